// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes,
// RX parity checker FSM states, parity helpers.
package uart_pkg;

  localparam logic [2:0] PAR_EVEN  = 3'd0;
  localparam logic [2:0] PAR_ODD   = 3'd1;
  localparam logic [2:0] PAR_MARK  = 3'd2;
  localparam logic [2:0] PAR_SPACE = 3'd3;
  localparam logic [2:0] PAR_NONE  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAR,
    ST_DONE
  } rx_par_state_e;

  // Codes 4..7 all mean no parity bit.
  function automatic logic par_is_none(
    input logic [2:0] mode
  );
    return mode[2];
  endfunction

  // Parity bit value a correct frame carries.
  function automatic logic par_expect(
    input logic [2:0] mode,
    input logic       acc
  );
    logic e;
    e = 1'b0;
    unique case (mode)
      PAR_EVEN:  e = acc;
      PAR_ODD:   e = ~acc;
      PAR_MARK:  e = 1'b1;
      PAR_SPACE: e = 1'b0;
      default:   e = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/rx_par_chk_gen_par_acc.sv
// Running XOR of a bit stream with sync clear.
// Shared between RX parity check and TX parity gen.
module par_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic acc
);

  logic acc_q;
  logic acc_d;

  // Clear wins over enable so a new frame starts at 0.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 1'b0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/rx_par_chk_gen.sv
// UART RX parity checker: assembles data bits,
// checks parity, flags strobe misuse, counts errors.
module rx_par_chk_gen
  import uart_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 8,
  localparam int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              frame_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [2:0]        par_mode,
  input  logic              bit_valid,
  input  logic              S_DATA,
  input  logic              par_strobe,
  input  logic              parity_bit,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              res_valid,
  output logic              par_err,
  output logic              seq_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

  rx_par_state_e state_q, state_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [2:0]        mode_q, mode_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              par_err_q, par_err_d;
  logic              res_valid_q, res_valid_d;
  logic              seq_err_q, seq_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              acc_clr;
  logic              acc_en;
  logic              acc;
  logic [LEN_W-1:0]  len_eff;
  logic              cnt_inc;

  par_acc u_par_acc (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (S_DATA),
    .acc   (acc)
  );

  // Zero or oversize lengths fall back to a full word.
  always_comb begin
    len_eff = cfg_len;
    if (cfg_len == '0 || cfg_len > LEN_MAX) begin
      len_eff = LEN_MAX;
    end
  end

  // Next-state, frame assembly and verdict.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    data_out_d  = data_out_q;
    par_err_d   = par_err_q;
    res_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;

    if (frame_start) begin
      // Start or restart; any strobe this cycle is dropped.
      state_d = ST_DATA;
      len_d   = len_eff;
      mode_d  = par_mode;
      cnt_d   = '0;
      word_d  = '0;
      acc_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          seq_err_d = bit_valid | par_strobe;
        end
        ST_DATA: begin
          seq_err_d = par_strobe;
          if (bit_valid) begin
            for (int i = 0; i < DATA_W; i++) begin
              if (cnt_q == LEN_W'(i)) begin
                word_d[i] = S_DATA;
              end
            end
            acc_en = 1'b1;
            cnt_d  = cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) begin
              if (par_is_none(mode_q)) begin
                state_d     = ST_DONE;
                res_valid_d = 1'b1;
                par_err_d   = 1'b0;
                data_out_d  = word_d;
              end else begin
                state_d = ST_PAR;
              end
            end
          end
        end
        ST_PAR: begin
          seq_err_d = bit_valid;
          if (par_strobe) begin
            state_d     = ST_DONE;
            res_valid_d = 1'b1;
            par_err_d   = parity_bit !=
                          par_expect(mode_q, acc);
            data_out_d  = word_q;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Count erroring frames on the edge that ends DONE.
  always_comb begin
    err_cnt_d = err_cnt_q;
    cnt_inc   = (state_q == ST_DONE) && par_err_q;
    if (err_clr) begin
      err_cnt_d = cnt_inc ? CNT_W'(1) : '0;
    end else if (cnt_inc && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      data_out_q  <= '0;
      par_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      data_out_q  <= data_out_d;
      par_err_q   <= par_err_d;
      res_valid_q <= res_valid_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data_out  = data_out_q;
  assign res_valid = res_valid_q;
  assign par_err   = par_err_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/rx_par_chk_gen.md
# rx_par_chk_gen

Parametrised receive-side parity checker for the UART RX path. Sits between the RX sampling FSM and the RX data/error outputs. Accepts sampled serial data bits and the parity bit as strobes, assembles the data word, and supports runtime frame length and five parity modes. Per frame it reports a parity verdict, and it also flags strobe-sequence violations and keeps a saturating error count.

## Interface
- `DATA_W`, 8: maximum data bits per frame (1..32).
- `CNT_W`, 8: width of the parity error counter.
- `LEN_W`, `$clog2(DATA_W+1)`: width of `cfg_len`. Derived, not overridable.

Ports:
- `CLK` — in, 1: single clock, rising edge.
- `RST` — in, 1: asynchronous, active-low reset.
- `frame_start` — in, 1: start-bit detected; opens a new frame and samples the config.
- `cfg_len` — in, `LEN_W`: data bits in the frame. 0 or >`DATA_W` is treated as `DATA_W`.
- `par_mode` — in, 3: 0 even, 1 odd, 2 mark, 3 space, 4–7 none.
- `bit_valid` — in, 1: `S_DATA` is a valid data bit this cycle.
- `S_DATA` — in, 1: sampled data bit, LSB first.
- `par_strobe` — in, 1: `parity_bit` is valid this cycle.
- `parity_bit` — in, 1: sampled parity bit.
- `err_clr` — in, 1: synchronous clear of `err_cnt`.
- `data_out` — out, `DATA_W`: assembled word; bits above `cfg_len` are 0.
- `res_valid` — out, 1: one-cycle pulse; `par_err`/`data_out` updated.
- `par_err` — out, 1: parity verdict of the last completed frame, held.
- `seq_err` — out, 1: one-cycle pulse on a strobe outside its legal state.
- `err_cnt` — out, `CNT_W`: saturating count of frames with `par_err`=1.
- `busy` — out, 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, DATA, PAR, DONE.
- IDLE + `frame_start` → DATA. Latches `len` (clamped `cfg_len`) and `mode` from `par_mode`. Clears the bit counter, accumulator and shift word.
- DATA, on `bit_valid`:
  - `word[cnt] <= S_DATA`
  - `acc <= acc ^ S_DATA`
  - `cnt++`
  - When `cnt == len-1` is accepted: go to PAR for modes 0–3, or DONE for mode none.
- PAR, on `par_strobe`, compute `exp`:
  - even: `exp = acc`
  - odd: `exp = ~acc`
  - mark: `exp = 1`
  - space: `exp = 0`
  - Then `err = (parity_bit != exp)`, go to DONE.
- Mode none: `err = 0`.
- DONE, one cycle:
  - `res_valid=1`, `par_err<=err`, `data_out<=word`.
  - If `err`, `err_cnt` increments, saturating at all-ones.
  - Then → IDLE.
- `frame_start` in any state other than IDLE: abort the current frame with no `res_valid`. Restart DATA with the new config. `seq_err` is not pulsed.
- `seq_err` pulses for:
  - `par_strobe` in IDLE or DATA
  - `bit_valid` in PAR
  - `bit_valid` or `par_strobe` in IDLE
- Strobes that raise `seq_err` are otherwise ignored.
- `frame_start` and `bit_valid` in the same cycle: the bit is ignored, with no `seq_err`.
- `err_clr` and an erroring DONE in the same cycle: `err_cnt` = 1.
- `err_clr` otherwise: `err_cnt` = 0.
- `par_mode`/`cfg_len` changes mid-frame have no effect.

## Timing
- Reset values (async, on `RST` low): state IDLE, `data_out`=0, `par_err`=0, `res_valid`=0, `seq_err`=0, `err_cnt`=0, `busy`=0. All internal registers cleared.
- `res_valid` rises exactly one cycle after the accepted `par_strobe`, or after the last data `bit_valid` in mode none. `par_err` and `data_out` are valid in that same cycle.
- `busy`: high from the cycle after `frame_start` through the DONE cycle.
- `seq_err`: registered, one cycle after the offending strobe.
- Back-to-back: `frame_start` may be asserted in the DONE cycle. DONE completes (`res_valid`) and the new frame enters DATA next.
- Reset mid-frame discards all progress; no `res_valid`.

## Structure
- Shared package `uart_pkg`:
  - Parity mode constants: `PAR_EVEN`=0, `PAR_ODD`=1, `PAR_MARK`=2, `PAR_SPACE`=3, `PAR_NONE`=4.
  - FSM state encoding for this block.
- One sub-module, `par_acc`: XOR accumulator with sync clear and enable. Reusable by the TX parity generator.
- FSM, counter, word assembly and error counter stay in the top.

## Test plan
- `DATA_W`=8, `cfg_len`=8, even mode, data `0xA5` (LSB first), `parity_bit`=0 → `res_valid` pulse, `data_out`=`0xA5`, `par_err`=0, `err_cnt`=0.
- Same frame with odd mode, `parity_bit`=0 → `par_err`=1, `err_cnt`=1. Then `err_clr` → `err_cnt`=0.
- `cfg_len`=5, mark mode, data `0x13`:
  - `parity_bit`=1 → `data_out`=`0x13`, `par_err`=0.
  - `parity_bit`=0 → `par_err`=1.
- Mode none, `cfg_len`=7, data `0x7F` → `res_valid` one cycle after the 7th bit, `par_err`=0. A following `par_strobe` → `seq_err` pulse, no state change.
- After 3 data bits, `frame_start` → no `res_valid`. Next full even frame `0x00`, `parity_bit`=0 → `par_err`=0, `data_out`=`0x00`.
- `CNT_W`=2: four erroring frames → `err_cnt`=3 (saturated). `RST` low mid-frame → all outputs return to 0 asynchronously.
